// File: rtl/status_flag_unit.sv
// Architectural N/Z/C/V flag register with masked update, registered
// branch-condition evaluation and a small LIFO flag stack for call/interrupt save.
module status_flag_unit #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    statusIn_i,
  input  logic          statusValid_i,
  input  logic [3:0]    flagMask_i,
  input  logic          condReq_i,
  input  logic [3:0]    condCode_i,
  input  logic          pushReq_i,
  input  logic          popReq_i,
  output logic [3:0]    flags_o,
  output logic          condValid_o,
  output logic          condTrue_o,
  output logic [CW-1:0] stackCount_o,
  output logic          stackFull_o,
  output logic          stackEmpty_o,
  output logic          stackErr_o
);

  localparam int ST_NEG      = 3;
  localparam int ST_ZERO     = 2;
  localparam int ST_CARRY    = 1;
  localparam int ST_OVERFLOW = 0;
  localparam int AW          = $clog2(DEPTH);

  logic [3:0]    flags_q, flags_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic          cond_valid_q;
  logic          cond_true_q, cond_true_d;
  logic [3:0]    stack_q [DEPTH];

  logic          full, empty, do_push, do_pop, both_req;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          n_f, z_f, c_f, v_f;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign both_req = pushReq_i & popReq_i;
  assign do_push  = pushReq_i & ~popReq_i & ~full;
  assign do_pop   = popReq_i & ~pushReq_i & ~empty;
  assign wr_ptr   = AW'(count_q);
  assign rd_ptr   = AW'(count_q - CW'(1));

  assign n_f = flags_q[ST_NEG];
  assign z_f = flags_q[ST_ZERO];
  assign c_f = flags_q[ST_CARRY];
  assign v_f = flags_q[ST_OVERFLOW];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    flags_d     = flags_q;
    count_d     = count_q;
    err_d       = err_q;
    cond_true_d = cond_true_q;

    if (do_pop) begin
      flags_d = stack_q[rd_ptr];
      count_d = count_q - CW'(1);
    end else if (statusValid_i) begin
      flags_d = (flags_q & ~flagMask_i) | (statusIn_i & flagMask_i);
    end

    if (do_push) count_d = count_q + CW'(1);

    if (both_req || (pushReq_i && full) || (popReq_i && empty)) err_d = 1'b1;

    // Evaluated on the pre-update flags; a same-cycle statusIn is not forwarded.
    if (condReq_i) begin
      case (condCode_i)
        4'd0:  cond_true_d = z_f;
        4'd1:  cond_true_d = ~z_f;
        4'd2:  cond_true_d = c_f;
        4'd3:  cond_true_d = ~c_f;
        4'd4:  cond_true_d = n_f;
        4'd5:  cond_true_d = ~n_f;
        4'd6:  cond_true_d = v_f;
        4'd7:  cond_true_d = ~v_f;
        4'd8:  cond_true_d = c_f & ~z_f;
        4'd9:  cond_true_d = ~c_f | z_f;
        4'd10: cond_true_d = (n_f == v_f);
        4'd11: cond_true_d = (n_f != v_f);
        4'd12: cond_true_d = ~z_f & (n_f == v_f);
        4'd13: cond_true_d = z_f | (n_f != v_f);
        4'd14: cond_true_d = 1'b1;
        default: cond_true_d = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q      <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
      cond_valid_q <= 1'b0;
      cond_true_q  <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      count_q      <= count_d;
      err_q        <= err_d;
      cond_valid_q <= condReq_i;
      cond_true_q  <= cond_true_d;
    end
  end

  // NOTE: stack storage is deliberately not reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) stack_q[wr_ptr] <= flags_q;
  end

  assign flags_o      = flags_q;
  assign condValid_o  = cond_valid_q;
  assign condTrue_o   = cond_true_q;
  assign stackCount_o = count_q;
  assign stackFull_o  = full;
  assign stackEmpty_o = empty;
  assign stackErr_o   = err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: flag update/masking, condition codes,
// flag stack fill/drain/error cases and reset mid-operation.
module tb_status_flag_unit;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  // Flag encodings: N=8, Z=4, C=2, V=1.
  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    statusIn_i;
  logic          statusValid_i;
  logic [3:0]    flagMask_i;
  logic          condReq_i;
  logic [3:0]    condCode_i;
  logic          pushReq_i;
  logic          popReq_i;
  logic [3:0]    flags_o;
  logic          condValid_o;
  logic          condTrue_o;
  logic [CW-1:0] stackCount_o;
  logic          stackFull_o;
  logic          stackEmpty_o;
  logic          stackErr_o;

  int total = 0;
  int bad   = 0;

  status_flag_unit #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .statusIn_i(statusIn_i), .statusValid_i(statusValid_i), .flagMask_i(flagMask_i),
    .condReq_i(condReq_i), .condCode_i(condCode_i),
    .pushReq_i(pushReq_i), .popReq_i(popReq_i),
    .flags_o(flags_o), .condValid_o(condValid_o), .condTrue_o(condTrue_o),
    .stackCount_o(stackCount_o), .stackFull_o(stackFull_o),
    .stackEmpty_o(stackEmpty_o), .stackErr_o(stackErr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; statusIn_i = 4'h0; statusValid_i = 1'b0; flagMask_i = 4'h0;
    condReq_i = 1'b0; condCode_i = 4'h0; pushReq_i = 1'b0; popReq_i = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] v);
    statusIn_i = v; flagMask_i = 4'hF; statusValid_i = 1'b1;
    step();
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (flags_o !== 4'h0)       begin bad++; $display("FAIL reset_flags got=%h exp=0", flags_o); end
    total++; if (condValid_o !== 1'b0)   begin bad++; $display("FAIL reset_condValid got=%b exp=0", condValid_o); end
    total++; if (condTrue_o !== 1'b0)    begin bad++; $display("FAIL reset_condTrue got=%b exp=0", condTrue_o); end
    total++; if (stackCount_o !== 3'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", stackCount_o); end
    total++; if (stackEmpty_o !== 1'b1)  begin bad++; $display("FAIL reset_empty got=%b exp=1", stackEmpty_o); end
    total++; if (stackFull_o !== 1'b0)   begin bad++; $display("FAIL reset_full got=%b exp=0", stackFull_o); end
    total++; if (stackErr_o !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b exp=0", stackErr_o); end
  endtask

  task automatic test_update_eq();
    set_flags(4'h4);
    total++; if (flags_o !== 4'h4) begin bad++; $display("FAIL upd_z got=%h exp=4", flags_o); end
    condReq_i = 1'b1; condCode_i = 4'd0;
    step();
    total++; if ({condValid_o, condTrue_o} !== 2'b11) begin bad++; $display("FAIL eq_z got=%b exp=11", {condValid_o, condTrue_o}); end
    condCode_i = 4'd1;
    step();
    total++; if ({condValid_o, condTrue_o} !== 2'b10) begin bad++; $display("FAIL ne_z got=%b exp=10", {condValid_o, condTrue_o}); end
    idle();
    step();
    total++; if ({condValid_o, condTrue_o} !== 2'b00) begin bad++; $display("FAIL cond_hold got=%b exp=00", {condValid_o, condTrue_o}); end
  endtask

  task automatic test_mask();
    statusIn_i = 4'h8; flagMask_i = 4'h8; statusValid_i = 1'b1;
    step();
    idle();
    total++; if (flags_o !== 4'hC) begin bad++; $display("FAIL mask_nz got=%h exp=c", flags_o); end
    statusIn_i = 4'h3; flagMask_i = 4'h3; // valid low: must not update
    step();
    total++; if (flags_o !== 4'hC) begin bad++; $display("FAIL no_valid got=%h exp=c", flags_o); end
    idle();
    condReq_i = 1'b1; condCode_i = 4'd13;
    step();
    total++; if ({condValid_o, condTrue_o} !== 2'b11) begin bad++; $display("FAIL le got=%b exp=11", {condValid_o, condTrue_o}); end
    condCode_i = 4'd12;
    step();
    total++; if ({condValid_o, condTrue_o} !== 2'b10) begin bad++; $display("FAIL gt got=%b exp=10", {condValid_o, condTrue_o}); end
    idle();
  endtask

  task automatic test_same_cycle();
    statusIn_i = 4'h0; flagMask_i = 4'h4; statusValid_i = 1'b1;
    condReq_i = 1'b1; condCode_i = 4'd0;
    step();
    idle();
    total++; if (condTrue_o !== 1'b1) begin bad++; $display("FAIL nofwd_old got=%b exp=1", condTrue_o); end
    total++; if (flags_o !== 4'h8)    begin bad++; $display("FAIL nofwd_flags got=%h exp=8", flags_o); end
    condReq_i = 1'b1; condCode_i = 4'd0;
    step();
    idle();
    total++; if ({condValid_o, condTrue_o} !== 2'b10) begin bad++; $display("FAIL nofwd_new got=%b exp=10", {condValid_o, condTrue_o}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  fv  [3] = '{4'h8, 4'h7, 4'h2};
    logic [15:0] exp [3] = '{16'h6A9A, 16'h6A65, 16'h55A6};
    for (int k = 0; k < 3; k++) begin
      set_flags(fv[k]);
      for (int i = 0; i < 16; i++) begin
        condReq_i = 1'b1; condCode_i = 4'(i);
        step();
        total++;
        if ({condValid_o, condTrue_o} !== {1'b1, exp[k][i]}) begin
          bad++;
          $display("FAIL cc flags=%h code=%0d got=%b exp=1%b", fv[k], i, {condValid_o, condTrue_o}, exp[k][i]);
        end
      end
      idle();
    end
  endtask

  task automatic test_stack_fill();
    logic [3:0] vals [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_flags(vals[i]);
      pushReq_i = 1'b1;
      step();
      idle();
      total++; if (stackCount_o !== 3'(i + 1)) begin bad++; $display("FAIL push_count i=%0d got=%0d exp=%0d", i, stackCount_o, i + 1); end
    end
    total++; if ({stackFull_o, stackEmpty_o, stackErr_o} !== 3'b100) begin bad++; $display("FAIL full_state got=%b exp=100", {stackFull_o, stackEmpty_o, stackErr_o}); end
    pushReq_i = 1'b1;
    step();
    idle();
    total++; if (stackErr_o !== 1'b1)   begin bad++; $display("FAIL overflow_err got=%b exp=1", stackErr_o); end
    total++; if (stackCount_o !== 3'd4) begin bad++; $display("FAIL overflow_count got=%0d exp=4", stackCount_o); end
    set_flags(4'hF);
    for (int i = 3; i >= 0; i--) begin
      popReq_i = 1'b1;
      step();
      idle();
      total++; if (flags_o !== vals[i]) begin bad++; $display("FAIL pop_flags i=%0d got=%h exp=%h", i, flags_o, vals[i]); end
      total++; if (stackCount_o !== 3'(i)) begin bad++; $display("FAIL pop_count i=%0d got=%0d exp=%0d", i, stackCount_o, i); end
    end
    total++; if ({stackFull_o, stackEmpty_o} !== 2'b01) begin bad++; $display("FAIL empty_state got=%b exp=01", {stackFull_o, stackEmpty_o}); end
    popReq_i = 1'b1;
    step();
    idle();
    total++; if (flags_o !== 4'h1)      begin bad++; $display("FAIL underflow_flags got=%h exp=1", flags_o); end
    total++; if (stackCount_o !== 3'd0) begin bad++; $display("FAIL underflow_count got=%0d exp=0", stackCount_o); end
  endtask

  task automatic test_push_pop_update();
    do_reset();
    set_flags(4'h5);
    pushReq_i = 1'b1; statusIn_i = 4'hA; flagMask_i = 4'hF; statusValid_i = 1'b1;
    step();
    idle();
    total++; if (flags_o !== 4'hA)      begin bad++; $display("FAIL push_upd_flags got=%h exp=a", flags_o); end
    total++; if (stackCount_o !== 3'd1) begin bad++; $display("FAIL push_upd_count got=%0d exp=1", stackCount_o); end
    popReq_i = 1'b1; statusIn_i = 4'h3; flagMask_i = 4'hF; statusValid_i = 1'b1;
    step();
    idle();
    total++; if (flags_o !== 4'h5)      begin bad++; $display("FAIL pop_upd_flags got=%h exp=5", flags_o); end
    total++; if (stackErr_o !== 1'b0)   begin bad++; $display("FAIL pop_upd_err got=%b exp=0", stackErr_o); end
    popReq_i = 1'b1; statusIn_i = 4'h6; flagMask_i = 4'hF; statusValid_i = 1'b1;
    step();
    idle();
    total++; if (flags_o !== 4'h6)    begin bad++; $display("FAIL empty_pop_upd got=%h exp=6", flags_o); end
    total++; if (stackErr_o !== 1'b1) begin bad++; $display("FAIL empty_pop_err got=%b exp=1", stackErr_o); end
  endtask

  task automatic test_both_and_reset();
    do_reset();
    set_flags(4'h9);
    pushReq_i = 1'b1;
    step();
    idle();
    pushReq_i = 1'b1; popReq_i = 1'b1; statusIn_i = 4'h2; flagMask_i = 4'h2; statusValid_i = 1'b1;
    step();
    idle();
    total++; if (stackErr_o !== 1'b1)   begin bad++; $display("FAIL both_err got=%b exp=1", stackErr_o); end
    total++; if (stackCount_o !== 3'd1) begin bad++; $display("FAIL both_count got=%0d exp=1", stackCount_o); end
    total++; if (flags_o !== 4'hB)      begin bad++; $display("FAIL both_flags got=%h exp=b", flags_o); end
    condReq_i = 1'b1; condCode_i = 4'd14;
    step();
    total++; if ({condValid_o, condTrue_o} !== 2'b11) begin bad++; $display("FAIL al got=%b exp=11", {condValid_o, condTrue_o}); end
    reset = 1'b1; condReq_i = 1'b1; condCode_i = 4'd14;
    step();
    idle();
    total++; if ({condValid_o, condTrue_o} !== 2'b00) begin bad++; $display("FAIL rst_cond got=%b exp=00", {condValid_o, condTrue_o}); end
    total++; if ({flags_o, stackCount_o} !== 7'h00)   begin bad++; $display("FAIL rst_state got=%h/%0d exp=0/0", flags_o, stackCount_o); end
    total++; if ({stackEmpty_o, stackFull_o, stackErr_o} !== 3'b100) begin bad++; $display("FAIL rst_stack got=%b exp=100", {stackEmpty_o, stackFull_o, stackErr_o}); end
    step();
    total++; if (condValid_o !== 1'b0) begin bad++; $display("FAIL rst_after got=%b exp=0", condValid_o); end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_update_eq();
    test_mask();
    test_same_cycle();
    test_back_to_back();
    test_stack_fill();
    test_push_pop_update();
    test_both_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
